alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream/downstream sequencing stage around the 4-bit combinational ALU.
- Assembles an ALU command from a 4-bit nibble stream (opcode, A, B), drives the ALU operand/select inputs from registers, and waits a fixed number of cycles.
- Captures the ALU result and flags into output registers, then presents them with a valid/ready handshake.
- Supports a chain mode that reuses the previous result's low nibble as operand A.

Parameters:
- EXEC_CYCLES, 1, cycles spent in EXEC before result capture; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data nibble is valid.
- in_ready  output  1  block accepts a nibble this cycle.
- in_data  input  4  command nibble: opcode, then A, then B.
- alu_a  output  4  registered operand A to ALU.
- alu_b  output  4  registered operand B to ALU.
- alu_sel  output  3  registered ALU selector.
- alu_result  input  8  ALU result.
- alu_carry  input  1  ALU carry/borrow.
- alu_zero  input  1  ALU zero flag.
- out_valid  output  1  captured result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  8  captured result.
- out_carry  output  1  captured carry.
- out_zero  output  1  captured zero.
- busy  output  1  high in EXEC and HOLD.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state LOAD_OP; alu_a/alu_b/alu_sel = 0; out_result = 0x00; out_carry = 0; out_zero = 0; out_valid = 0; chain register = 0x0; exec counter = 0.
- While rst is high, in_ready = 0 and out_valid = 0.
- Nibble accept: a nibble is consumed on a clock edge where in_valid && in_ready.
- in_ready = 1 exactly in LOAD_OP, LOAD_A and LOAD_B (combinational decode of the state).
- LOAD_OP, on accept:
  - alu_sel <= in_data[2:0] and chain <= in_data[3].
  - If in_data[3] = 1: alu_a <= chain_reg and next state is LOAD_B.
  - Otherwise next state is LOAD_A.
- LOAD_A, on accept: alu_a <= in_data; next state LOAD_B.
- LOAD_B, on accept: alu_b <= in_data; counter <= EXEC_CYCLES-1; next state EXEC.
- EXEC: ALU inputs held stable.
  - When counter = 0: out_result <= alu_result, out_carry <= alu_carry, out_zero <= alu_zero, chain_reg <= alu_result[3:0]; next state HOLD.
  - Otherwise the counter decrements.
- Latency: B accepted at edge N; out_valid first high in the cycle after edge N+EXEC_CYCLES.
- HOLD: out_valid = 1. Outputs and chain_reg are stable until out_valid && out_ready; on that edge the state goes to LOAD_OP.
  - in_ready returns high the cycle after the handshake; there is no overlap between result hold and command load.
- Any in_valid without in_ready is ignored; no nibble is buffered.
- Opcode 3'b111 is passed through; the ALU returns 0 and zero = 1, and this is captured unchanged.
- Reset mid-operation, in any state: the partial command is discarded, chain_reg is cleared, and there is no spurious out_valid.
- Reset while out_valid is high: out_valid drops on the reset edge.
- Simultaneous rst and handshake: reset wins.

Optional Feature:
- Macro: ALU_DIV0_FLAG_EN.
- Enabled:
  - Adds port out_div0 (output, 1 bit, reset 0).
  - In EXEC, if alu_sel = 3'b110 and alu_b = 0: capture out_div0 = 1, out_result = 0xFF, out_zero = 0, out_carry = 0, and chain_reg = 0xF.
  - Otherwise out_div0 = 0.
- Disabled: no out_div0 port, and the ALU output is captured unchanged for every opcode.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_MUL=5, OP_DIV=6, OP_NOP=7.
  - CHAIN_BIT index 3.
  - State encoding LOAD_OP, LOAD_A, LOAD_B, EXEC, HOLD.
- No sub-module: the FSM, exec counter and capture registers stay in one module.
- The ALU is instantiated beside this block by the parent, not inside it.

Test Plan:
- ADD, no backpressure: nibbles 0x0, 0x5, 0x3 back-to-back, EXEC_CYCLES=1, out_ready=1 -> alu_a=5, alu_b=3, out_result=0x08, carry=0, zero=0; out_valid exactly one cycle, 2 cycles after B accepted.
- SUB borrow: nibbles 0x1, 0x3, 0x5 -> out_result=0xFE, out_carry=1, out_zero=0.
- Chain: after SUB, nibbles 0x8, 0x2 (2 nibbles only) -> alu_a=0xE, out_result=0x10, carry=0.
- Backpressure/stalls:
  - Hold out_ready=0 for 5 cycles while toggling in_valid -> out_valid held, result stable, in_ready=0, busy=1, no nibble consumed.
  - in_valid gaps between nibbles must not corrupt the command.
- Reset mid-op: opcode 0x2 and A=0xF accepted, pulse rst in LOAD_B -> in_ready=1, out_valid=0, chain_reg=0; then chain command 0x8, 0x7 -> alu_a=0, out_result=0x07.
- Div-by-zero and exec length:
  - With ALU_DIV0_FLAG_EN, nibbles 0x6, 0x9, 0x0 -> out_div0=1, out_result=0xFF.
  - Without the macro -> out_result passes the ALU value.
  - Repeat with EXEC_CYCLES=4 -> out_valid 5 cycles after B.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU
// command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam int CHAIN_BIT = 3;

  typedef enum logic [2:0] {
    LOAD_OP,
    LOAD_A,
    LOAD_B,
    EXEC,
    HOLD
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Nibble-stream command sequencer in front of the 4-bit ALU.
// Optional divide-by-zero flag: define ALU_DIV0_FLAG_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_carry,
`ifdef ALU_DIV0_FLAG_EN
  output logic       out_zero,
  output logic       out_div0,
`else
  output logic       out_zero,
`endif
  output logic       busy
);

  state_t     state;
  state_t     nxt;
  logic [1:0] cnt;
  logic [3:0] chain_reg;
  logic       accept;
  logic [7:0] cap_result;
  logic       cap_carry;
  logic       cap_zero;
  logic       cap_div0;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_OP;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      LOAD_OP:
        if (accept)
          nxt = in_data[CHAIN_BIT] ? LOAD_B : LOAD_A;
      LOAD_A:
        if (accept) nxt = LOAD_B;
      LOAD_B:
        if (accept) nxt = EXEC;
      EXEC:
        if (cnt == 2'd0) nxt = HOLD;
      HOLD:
        if (out_ready) nxt = LOAD_OP;
      default: nxt = LOAD_OP;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      state == LOAD_OP,
      state == LOAD_A,
      state == LOAD_B: in_ready = !rst;
      state == EXEC:   busy = 1'b1;
      state == HOLD: begin
        busy      = 1'b1;
        out_valid = !rst;
      end
      default: ;
    endcase
  end

  // Divide-by-zero override replaces whatever the ALU reports.
  always_comb begin
    cap_result = alu_result;
    cap_carry  = alu_carry;
    cap_zero   = alu_zero;
    cap_div0   = 1'b0;
`ifdef ALU_DIV0_FLAG_EN
    if (alu_sel == OP_DIV && alu_b == 4'h0) begin
      cap_result = 8'hFF;
      cap_carry  = 1'b0;
      cap_zero   = 1'b0;
      cap_div0   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= 4'h0;
      alu_b      <= 4'h0;
      alu_sel    <= 3'd0;
      out_result <= 8'h00;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      chain_reg  <= 4'h0;
      cnt        <= 2'd0;
`ifdef ALU_DIV0_FLAG_EN
      out_div0   <= 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD_OP:
          if (accept) begin
            alu_sel <= in_data[2:0];
            if (in_data[CHAIN_BIT]) alu_a <= chain_reg;
          end
        LOAD_A:
          if (accept) alu_a <= in_data;
        LOAD_B:
          if (accept) begin
            alu_b <= in_data;
            cnt   <= 2'(EXEC_CYCLES - 1);
          end
        EXEC:
          if (cnt == 2'd0) begin
            out_result <= cap_result;
            out_carry  <= cap_carry;
            out_zero   <= cap_zero;
            chain_reg  <= cap_result[3:0];
`ifdef ALU_DIV0_FLAG_EN
            out_div0   <= cap_div0;
`endif
          end else begin
            cnt <= cnt - 2'd1;
          end
        default: ;
      endcase
    end
  end

`ifndef ALU_DIV0_FLAG_EN
  logic unused_div0;
  assign unused_div0 = cap_div0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer with a transaction-level
// reference model and a behavioural ALU beside the DUT.
module tb_alu_cmd_sequencer;

  localparam int EC = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       busy;
  logic       div0;

  logic       d4_in_valid;
  logic       d4_in_ready;
  logic [3:0] d4_in_data;
  logic [3:0] d4_alu_a;
  logic [3:0] d4_alu_b;
  logic [2:0] d4_alu_sel;
  logic [7:0] d4_alu_result;
  logic       d4_alu_carry;
  logic       d4_alu_zero;
  logic       d4_out_valid;
  logic [7:0] d4_out_result;
  logic       d4_out_carry;
  logic       d4_out_zero;
  logic       d4_busy;
  logic       d4_div0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] m_chain;

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, zero, result}
  function automatic logic [9:0] alu_f(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] sel
  );
    int   r;
    logic c;
    c = 1'b0;
    case (sel)
      3'd0: r = int'(a) + int'(b);
      3'd1: begin
        r = (int'(a) - int'(b)) & 255;
        c = a < b;
      end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(a) * int'(b);
      3'd6: r = (b == 0) ? 0 : int'(a) / int'(b);
      default: r = 0;
    endcase
    return {c, (r == 0), 8'(r)};
  endfunction

  assign {alu_carry, alu_zero, alu_result} =
    alu_f(alu_a, alu_b, alu_sel);
  assign {d4_alu_carry, d4_alu_zero, d4_alu_result} =
    alu_f(d4_alu_a, d4_alu_b, d4_alu_sel);

  alu_cmd_sequencer #(.EXEC_CYCLES(EC)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero),
`ifdef ALU_DIV0_FLAG_EN
    .out_div0(div0),
`endif
    .busy(busy)
  );

  alu_cmd_sequencer #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_data(d4_in_data),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b),
    .alu_sel(d4_alu_sel),
    .alu_result(d4_alu_result), .alu_carry(d4_alu_carry),
    .alu_zero(d4_alu_zero),
    .out_valid(d4_out_valid), .out_ready(1'b1),
    .out_result(d4_out_result), .out_carry(d4_out_carry),
    .out_zero(d4_out_zero),
`ifdef ALU_DIV0_FLAG_EN
    .out_div0(d4_div0),
`endif
    .busy(d4_busy)
  );

`ifndef ALU_DIV0_FLAG_EN
  assign div0    = 1'b0;
  assign d4_div0 = 1'b0;
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [3:0] d);
    int k;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_cmd(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ch,
    input int         stall
  );
    logic [3:0] ea;
    logic [9:0] r;
    logic [7:0] er;
    logic       ec;
    logic       ez;
    logic       ed;
    int         k;
    ea = ch ? m_chain : a;
    r  = alu_f(ea, b, op);
    er = r[7:0];
    ez = r[8];
    ec = r[9];
    ed = 1'b0;
`ifdef ALU_DIV0_FLAG_EN
    if (op == 3'd6 && b == 4'h0) begin
      er = 8'hFF;
      ez = 1'b0;
      ec = 1'b0;
      ed = 1'b1;
    end
`endif
    send({ch, op});
    if (!ch) send(a);
    send(b);
    out_ready = (stall == 0);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, EC);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, b);
    chk("alu_sel", alu_sel, op);
    chk("result", out_result, er);
    chk("carry", out_carry, ec);
    chk("zero", out_zero, ez);
    chk("div0", div0, ed);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
      chk("hold_result", out_result, er);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    m_chain = er[3:0];
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    d4_in_valid = 1'b0;
    d4_in_data  = 4'h0;
    m_chain   = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_result", out_result, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    do_cmd(3'd0, 4'h5, 4'h3, 1'b0, 0);
    chk("add_lit", out_result, 8'h08);
    do_cmd(3'd1, 4'h3, 4'h5, 1'b0, 0);
    chk("sub_lit", {out_carry, out_result}, 9'h1FE);
    do_cmd(3'd0, 4'h0, 4'h2, 1'b1, 5);
    chk("chain_a_lit", alu_a, 4'hE);
    chk("chain_lit", out_result, 8'h10);
    do_cmd(3'd7, 4'hA, 4'hB, 1'b0, 1);
    chk("nop_lit", {out_zero, out_result}, 9'h100);
    do_cmd(3'd6, 4'h9, 4'h0, 1'b0, 0);
`ifdef ALU_DIV0_FLAG_EN
    chk("div0_lit", {div0, out_result}, 9'h1FF);
`else
    chk("div0_lit", {div0, out_result}, 9'h000);
`endif

    // reset while a command is half loaded
    send(4'h2);
    send(4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst = 1'b0;
    m_chain = 4'h0;
    @(negedge clk);
    chk("mid_post_ready", in_ready, 1);
    chk("mid_post_valid", out_valid, 0);
    do_cmd(3'd0, 4'h0, 4'h7, 1'b1, 0);
    chk("mid_chain_lit", out_result, 8'h07);

    // reset while the result is being held
    out_ready = 1'b0;
    send(4'h0);
    send(4'h4);
    send(4'h4);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("hold_seen", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("hold_rst_valid", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    m_chain = 4'h0;
    @(negedge clk);
    chk("hold_rst_ready", in_ready, 1);

    for (int t = 0; t < 40; t++)
      do_cmd(3'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), $urandom_range(0, 5));

    // four-cycle EXEC instance
    foreach (k4_nibs[i]) begin
      @(negedge clk);
      chk("d4_ready", d4_in_ready, 1);
      d4_in_valid = 1'b1;
      d4_in_data  = k4_nibs[i];
    end
    @(posedge clk);
    #1;
    d4_in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!d4_out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("d4_latency", k, 4);
    chk("d4_result", d4_out_result, 8'h08);
    @(negedge clk);
    chk("d4_valid_drop", d4_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  logic [3:0] k4_nibs [3] = '{4'h0, 4'h5, 4'h3};

endmodule
